// File: rtl/my_and.sv
// -----------------------------------------------------------------------------
// my_and -- two-input AND with a registered copy, a rising-edge pulse and an
// optional saturating count of clock edges at which the AND output was high.
//
// Build option:
//   MY_AND_STATS_EN  when defined, compiles in the high_cnt counter.
//                    When undefined, high_cnt is tied to 0 and the design
//                    contains no counter flops.
//
// Parameters:
//   CNT_W     width of the high-cycle counter (legal range 2..32)
//
// Ports (in1, in2, out come first so a legacy positional hookup still binds):
//   in1       first AND operand
//   in2       second AND operand
//   out       combinational in1 & in2, never touched by clk or rst
//   clk       single clock, rising-edge active
//   rst       synchronous active-high reset
//   out_q     out delayed by one clock
//   out_rise  one-cycle pulse, high in the first cycle out_q reads 1
//   high_cnt  saturating count of edges at which out was 1 (0 without stats)
// -----------------------------------------------------------------------------
module my_and #(
  parameter int CNT_W = 16
) (
  input  logic             in1,
  input  logic             in2,
  output logic             out,
  input  logic             clk,
  input  logic             rst,
  output logic             out_q,
  output logic             out_rise,
  output logic [CNT_W-1:0] high_cnt
);

  // Purely combinational path; rst deliberately has no influence here.
  assign out = in1 & in2;

  logic out_q_d;
  logic rise_d;

  always_comb begin
    out_q_d = out;
    // Registered pulse: computed from the value about to be loaded and the
    // current registered value, so it lands in the same cycle out_q goes high.
    rise_d  = out & ~out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= 1'b0;
      out_rise <= 1'b0;
    end else begin
      out_q    <= out_q_d;
      out_rise <= rise_d;
    end
  end

`ifdef MY_AND_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // Stop at all-ones instead of wrapping back to zero.
    if (out && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset wins over any pending increment on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign high_cnt = cnt_q;
`else
  assign high_cnt = '0;
`endif

endmodule

// File: tb/tb_my_and.sv
// -----------------------------------------------------------------------------
// tb_my_and -- self-checking bench for my_and. Two instances are exercised in
// lockstep: the default CNT_W=16 and a CNT_W=2 copy that saturates quickly.
// Expected values come from a cycle-level model of the behavioural rules.
// -----------------------------------------------------------------------------
module tb_my_and;

`ifdef MY_AND_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in1;
  logic        in2;
  logic        clk_run;

  logic        out_a, out_q_a, rise_a;
  logic [15:0] cnt_a;
  logic        out_b, out_q_b, rise_b;
  logic [1:0]  cnt_b;

  my_and #(.CNT_W(16)) u_dut_a (
    .in1      (in1),
    .in2      (in2),
    .out      (out_a),
    .clk      (clk),
    .rst      (rst),
    .out_q    (out_q_a),
    .out_rise (rise_a),
    .high_cnt (cnt_a)
  );

  my_and #(.CNT_W(2)) u_dut_b (
    .in1      (in1),
    .in2      (in2),
    .out      (out_b),
    .clk      (clk),
    .rst      (rst),
    .out_q    (out_q_b),
    .out_rise (rise_b),
    .high_cnt (cnt_b)
  );

  // Clock stays parked low until the combinational phase is over.
  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_q;
  bit          m_rise;
  longint      m_cnt_a;
  longint      m_cnt_b;

  // One clock: apply inputs (caller is at a negedge), take the edge, update
  // the model from the pre-edge inputs, then compare just after the edge.
  task automatic step(input bit a, input bit b, input bit r, input string tag);
    bit o;
    in1 = a;
    in2 = b;
    rst = r;
    #1;
    o = a & b;
    chk({tag, ".out_pre"}, {31'd0, out_a}, {31'd0, o});
    @(posedge clk);
    if (r) begin
      m_q     = 1'b0;
      m_rise  = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else begin
      m_rise  = o && !m_q;
      m_q     = o;
      m_cnt_a = (m_cnt_a + o > 65535) ? 65535 : m_cnt_a + o;
      m_cnt_b = (m_cnt_b + o > 3)     ? 3     : m_cnt_b + o;
    end
    #1;
    chk({tag, ".out"},      {31'd0, out_a},   {31'd0, o});
    chk({tag, ".out_b"},    {31'd0, out_b},   {31'd0, o});
    chk({tag, ".out_q"},    {31'd0, out_q_a}, {31'd0, m_q});
    chk({tag, ".out_q_b"},  {31'd0, out_q_b}, {31'd0, m_q});
    chk({tag, ".rise"},     {31'd0, rise_a},  {31'd0, m_rise});
    chk({tag, ".rise_b"},   {31'd0, rise_b},  {31'd0, m_rise});
    chk({tag, ".cnt"},      {16'd0, cnt_a},   STATS ? 32'(m_cnt_a) : 32'd0);
    chk({tag, ".cnt_b"},    {30'd0, cnt_b},   STATS ? 32'(m_cnt_b) : 32'd0);
    $display("step %-8s in=%0b%0b rst=%0b out=%0b out_q=%0b rise=%0b cnt=%0d cnt_b=%0d",
             tag, a, b, r, out_a, out_q_a, rise_a, cnt_a, cnt_b);
    @(negedge clk);
  endtask

  initial begin
    bit tt_a [5];
    bit tt_b [5];
    n_cmp   = 0;
    n_bad   = 0;
    clk_run = 1'b0;
    rst     = 1'b0;
    in1     = 1'b0;
    in2     = 1'b0;
    m_q     = 1'b0;
    m_rise  = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;

    // Combinational truth table with no clock running.
    tt_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tt_b = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      in1 = tt_a[i];
      in2 = tt_b[i];
      #0;
      #0;
      chk("tt.out", {31'd0, out_a}, {31'd0, tt_a[i] & tt_b[i]});
      $display("tt in=%0b%0b out=%0b", in1, in2, out_a);
      #10;
    end

    // Start clock and apply reset.
    clk_run = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b1, "rst0");
    step(1'b1, 1'b1, 1'b1, "rst1");

    // First edge after reset with out=1: out_q goes high and rise pulses.
    step(1'b1, 1'b1, 1'b0, "lat_n");
    chk("lat.rise_n", {31'd0, rise_a}, 32'd1);
    step(1'b1, 1'b1, 1'b0, "lat_n1");
    chk("lat.rise_n1", {31'd0, rise_a}, 32'd0);

    // Counter: 5 edges of 11, then 3 edges of 01.
    step(1'b0, 1'b0, 1'b1, "crst");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, "c11");
    chk("cnt.after11", {16'd0, cnt_a}, STATS ? 32'd5 : 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "c01");
    chk("cnt.after01", {16'd0, cnt_a}, STATS ? 32'd5 : 32'd0);
    chk("sat.b", {30'd0, cnt_b}, STATS ? 32'd3 : 32'd0);

    // Saturation on the narrow instance: 6 edges of 11.
    step(1'b0, 1'b0, 1'b1, "srst");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, "s11");
    chk("sat.hold", {30'd0, cnt_b}, STATS ? 32'd3 : 32'd0);

    // Reset mid-count with inputs still high.
    step(1'b0, 1'b0, 1'b1, "mrst0");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, "m11");
    chk("mid.cnt4", {16'd0, cnt_a}, STATS ? 32'd4 : 32'd0);
    step(1'b1, 1'b1, 1'b1, "mrst");
    chk("mid.out_q", {31'd0, out_q_a}, 32'd0);
    chk("mid.cnt0",  {16'd0, cnt_a},   32'd0);
    chk("mid.out",   {31'd0, out_a},   32'd1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/my_and.md
MY_AND -- requirements
Module: my_and

Interface
REQ-001 Parameter CNT_W, default 16: width of the high-cycle counter; legal range 2..32.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high, sampled on the rising edge of clk.
REQ-004 Port in1, input, 1: first AND operand.
REQ-005 Port in2, input, 1: second AND operand.
REQ-006 Port out, output, 1: combinational in1 AND in2.
REQ-007 Port out_q, output, 1: registered copy of out.
REQ-008 Port out_rise, output, 1: single-cycle pulse on the 0->1 transition of out_q.
REQ-009 Port high_cnt, output, CNT_W: saturating count of clock edges at which out was 1.
REQ-010 Positional order of the first three data ports shall be in1, in2, out, so a legacy three-port positional connection (in1, in2, out) binds correctly; clk and rst are bound by name.

Function
REQ-011 out shall equal in1 & in2 with zero-cycle latency, independent of clk and rst.
- Truth table: 00->0, 01->0, 10->0, 11->1.
REQ-012 out shall not be gated, registered or forced by rst.
REQ-013 out_q shall load out on every rising clk edge with rst low; latency 1 cycle.
REQ-014 out_rise shall be 1 for exactly one cycle when out_q changes 0->1; otherwise 0.
- Registered, so it is asserted in the same cycle out_q first reads 1.
REQ-015 high_cnt shall increment by 1 on each rising edge with rst low and out = 1.
REQ-016 high_cnt shall saturate at 2^CNT_W-1 and shall not wrap.
REQ-017 high_cnt shall hold when out = 0.
REQ-018 An X/Z on in1 or in2 need not be resolved; with either input 0, out shall be 0 irrespective of the other.

Reset
REQ-019 On a rising clk edge with rst = 1:
- out_q -> 0
- out_rise -> 0
- high_cnt -> 0
REQ-020 rst has priority over all increments and loads in the same cycle.
REQ-021 The first edge after rst deasserts resumes normal operation.
- If out = 1 at that edge, out_q becomes 1 and out_rise pulses.
REQ-022 Reset asserted mid-count shall clear high_cnt on that edge, with no residual increment.

Configuration
REQ-023 Macro MY_AND_STATS_EN compiles the statistics logic in or out.
REQ-024 With MY_AND_STATS_EN defined, high_cnt shall behave per REQ-015..REQ-017.
REQ-025 Without MY_AND_STATS_EN:
- high_cnt shall be tied to constant 0.
- No counter flops shall be synthesized.
- out, out_q and out_rise shall be unchanged.

Verification
REQ-026 Combinational truth table: drive in1/in2 = 00, 01, 10, 11, 00 at 10-time-unit spacing with no clock running -> out = 0, 0, 0, 1, 0, each settled within the same timestep.
REQ-027 Register latency: rst released; in1 = 1, in2 = 1 applied before edge N -> out_q = 1 and out_rise = 1 after edge N; out_rise = 0 after edge N+1.
REQ-028 Counter: hold 11 for 5 edges, then 01 for 3 edges -> high_cnt = 5, held through the 01 phase.
REQ-029 Saturation: CNT_W = 2, hold 11 for 6 edges -> high_cnt = 3, stays 3.
REQ-030 Reset mid-operation: high_cnt = 4 and out_q = 1; assert rst for 1 edge with in1 = in2 = 1 -> out_q = 0, out_rise = 0, high_cnt = 0, out still 1.
REQ-031 Build without MY_AND_STATS_EN, repeat REQ-028 stimulus -> high_cnt = 0 throughout; out and out_q identical to the stats-enabled build.
